ram_be_sync: RTL and testbench

- Parametrised successor to the team's single-port 256x32 data RAM; intended as the next-generation data memory behind the MIPS load/store unit.
- Adds per-byte write enables, a registered read with a one-cycle valid pulse, and a ready handshake.
- Adds an out-of-range error flag and a hardware initialisation sweep after reset.
- All storage updates occur on the rising edge of clk. There is no tri-state output.

---
 rtl/ram_be_sync.sv | 118 +++++++++++
 tb/tb_ram_be_sync.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_be_sync.sv
// Single-port synchronous RAM with per-byte write enables, registered read
// (one-cycle rvalid pulse), out-of-range error pulse and a post-reset init sweep.
module ram_be_sync #(
  parameter int              DW       = 32,
  parameter int              DEPTH    = 256,
  parameter int              AW       = $clog2(DEPTH),
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DW/8-1:0]   be,
  input  logic [DW-1:0]     wdata,
  output logic              ready,
  output logic [DW-1:0]     rdata,
  output logic              rvalid,
  output logic              err
);

  localparam int            NB       = DW / 8;
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW:0]   DepthExt = (AW + 1)'(DEPTH);

  typedef enum logic {StInit, StIdle} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic          accept;
  logic          inRange;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep counter parks on the last word; it never wraps into IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StInit: begin
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_comb begin
    ready = (state_q == StIdle);
  end

  assign accept  = req & ready;
  assign inRange = ({1'b0, addr} < DepthExt);

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      err_d = !inRange;
      if (!we) begin
        rvalid_d = 1'b1;
        rdata_d  = inRange ? mem[addr] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Storage has no reset; contents are restored only by the init sweep.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= INIT_VAL;
    end else if (accept && we && inRange) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ram_be_sync.sv
// Scoreboard bench for ram_be_sync: a 256-word instance (power-of-two depth)
// and a 200-word instance (out-of-range addresses reachable).
module tb_ram_be_sync;

  typedef struct {
    int          cyc;
    logic        rv;
    logic        er;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        reqA, weA, readyA, rvalidA, errA;
  logic [7:0]  addrA;
  logic [3:0]  beA;
  logic [31:0] wdataA, rdataA;

  logic        reqB, weB, readyB, rvalidB, errB;
  logic [7:0]  addrB;
  logic [3:0]  beB;
  logic [31:0] wdataB, rdataB;

  exp_t        qA[$];
  exp_t        qB[$];
  logic [31:0] lastRd [2];
  int          cycleCnt;
  int          checks;
  int          failures;

  ram_be_sync #(.DW(32), .DEPTH(256), .INIT_VAL(32'h0)) dutA (
    .clk(clk), .rst_n(rst_n), .req(reqA), .we(weA), .addr(addrA), .be(beA),
    .wdata(wdataA), .ready(readyA), .rdata(rdataA), .rvalid(rvalidA), .err(errA)
  );

  ram_be_sync #(.DW(32), .DEPTH(200), .INIT_VAL(32'h0)) dutB (
    .clk(clk), .rst_n(rst_n), .req(reqB), .we(weB), .addr(addrB), .be(beB),
    .wdata(wdataB), .ready(readyB), .rdata(rdataB), .rvalid(rvalidB), .err(errB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to timestamp when each expected response must appear.
  initial cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic expectVal(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, want);
    end
  endtask

  // Pops the scoreboard whenever a DUT presents rvalid/err; otherwise
  // checks rdata holds and that no expected response was skipped.
  task automatic checkOutput(input int dev, input logic rv, input logic er, input logic [31:0] rd);
    exp_t e;
    bit   have;
    have = 0;
    if (!rst_n) begin
      lastRd[dev] = '0;
      return;
    end
    if (rv || er) begin
      if (dev == 0 && qA.size() > 0) begin e = qA.pop_front(); have = 1; end
      else if (dev == 1 && qB.size() > 0) begin e = qB.pop_front(); have = 1; end
      checks++;
      if (!have) begin
        failures++;
        $display("[TB] FAIL unexpected_output dut%0d cyc=%0d: rvalid=%0b err=%0b rdata=%h, required no output",
                 dev, cycleCnt, rv, er, rd);
      end else begin
        checks++;
        if (e.cyc != cycleCnt) begin
          failures++;
          $display("[TB] FAIL latency dut%0d: output at cycle %0d, required cycle %0d", dev, cycleCnt, e.cyc);
        end
        checks++;
        if (rv !== e.rv || er !== e.er) begin
          failures++;
          $display("[TB] FAIL flags dut%0d cyc=%0d: rvalid=%0b err=%0b, required rvalid=%0b err=%0b",
                   dev, cycleCnt, rv, er, e.rv, e.er);
        end
        checks++;
        if (e.rv) begin
          if (rd !== e.data) begin
            failures++;
            $display("[TB] FAIL rdata dut%0d cyc=%0d: got %h, required %h", dev, cycleCnt, rd, e.data);
          end
          lastRd[dev] = e.data;
        end else if (rd !== lastRd[dev]) begin
          failures++;
          $display("[TB] FAIL rdata_hold_err dut%0d cyc=%0d: got %h, required %h", dev, cycleCnt, rd, lastRd[dev]);
        end
      end
    end else begin
      checks++;
      if (rd !== lastRd[dev]) begin
        failures++;
        $display("[TB] FAIL rdata_hold dut%0d cyc=%0d: got %h, required %h", dev, cycleCnt, rd, lastRd[dev]);
      end
      if (dev == 0 && qA.size() > 0 && qA[0].cyc <= cycleCnt) begin
        e = qA.pop_front();
        checks++;
        failures++;
        $display("[TB] FAIL missed_output dut0 cyc=%0d: no rvalid/err, required rvalid=%0b err=%0b", cycleCnt, e.rv, e.er);
      end else if (dev == 1 && qB.size() > 0 && qB[0].cyc <= cycleCnt) begin
        e = qB.pop_front();
        checks++;
        failures++;
        $display("[TB] FAIL missed_output dut1 cyc=%0d: no rvalid/err, required rvalid=%0b err=%0b", cycleCnt, e.rv, e.er);
      end
    end
  endtask

  // Monitor samples both DUTs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    checkOutput(0, rvalidA, errA, rdataA);
    checkOutput(1, rvalidB, errB, rdataB);
  end

  // Drives one request for a single edge and queues its expected response.
  task automatic applyStimulus(input int dev, input logic w, input logic [7:0] a, input logic [3:0] b,
                               input logic [31:0] d, input logic expRv, input logic expEr,
                               input logic [31:0] expData);
    exp_t e;
    @(negedge clk);
    if (dev == 0) begin
      reqA = 1'b1; weA = w; addrA = a; beA = b; wdataA = d; reqB = 1'b0;
    end else begin
      reqB = 1'b1; weB = w; addrB = a; beB = b; wdataB = d; reqA = 1'b0;
    end
    e.cyc  = cycleCnt + 1;
    e.rv   = expRv;
    e.er   = expEr;
    e.data = expData;
    if (expRv || expEr) begin
      if (dev == 0) qA.push_back(e);
      else          qB.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    reqA = 1'b0;
    reqB = 1'b0;
  endtask

  // Counts edges from rst_n release until ready is seen, bounded at 400.
  task automatic waitReady(input int dev, input int expCycles);
    int n;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if ((dev == 0) ? readyA : readyB) break;
    end
    checks++;
    if (n != expCycles) begin
      failures++;
      $display("[TB] FAIL init_length dut%0d: ready after %0d cycles, required %0d", dev, n, expCycles);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lastRd[0] = '0;
    lastRd[1] = '0;
    reqA = 0; weA = 0; addrA = 0; beA = 0; wdataA = 0;
    reqB = 0; weB = 0; addrB = 0; beB = 0; wdataB = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expectVal("reset_readyA",  {31'b0, readyA},  32'h0);
    expectVal("reset_rvalidA", {31'b0, rvalidA}, 32'h0);
    expectVal("reset_errA",    {31'b0, errA},    32'h0);
    expectVal("reset_rdataA",  rdataA,           32'h0);
    expectVal("reset_readyB",  {31'b0, readyB},  32'h0);

    // Release reset and hammer both instances with requests during the sweep.
    rst_n = 1'b1;
    fork
      waitReady(0, 256);
      waitReady(1, 200);
      begin
        reqA = 1'b1; weA = 1'b1; addrA = 8'd0; beA = 4'hF; wdataA = 32'hFFFFFFFF;
        reqB = 1'b1; weB = 1'b0; addrB = 8'd210; beB = 4'hF;
        repeat (150) @(negedge clk);
        reqA = 1'b0;
        reqB = 1'b0;
      end
    join

    applyStimulus(0, 0, 8'd0,   4'h0, 32'h0,        1, 0, 32'h0);
    applyStimulus(0, 0, 8'd127, 4'h0, 32'h0,        1, 0, 32'h0);
    applyStimulus(0, 0, 8'd255, 4'h0, 32'h0,        1, 0, 32'h0);
    applyStimulus(0, 1, 8'd5,   4'hF, 32'hAABBCCDD, 0, 0, 32'h0);
    applyStimulus(0, 1, 8'd5,   4'h5, 32'h11223344, 0, 0, 32'h0);
    applyStimulus(0, 0, 8'd5,   4'hF, 32'h0,        1, 0, 32'hAA22CC44);
    applyStimulus(0, 1, 8'd5,   4'h0, 32'hFFFFFFFF, 0, 0, 32'h0);
    applyStimulus(0, 0, 8'd5,   4'h0, 32'h0,        1, 0, 32'hAA22CC44);
    applyStimulus(0, 1, 8'd3,   4'hF, 32'hDEADBEEF, 0, 0, 32'h0);
    applyStimulus(0, 0, 8'd3,   4'h0, 32'h0,        1, 0, 32'hDEADBEEF);
    applyStimulus(0, 0, 8'd4,   4'h0, 32'h0,        1, 0, 32'h0);
    applyStimulus(0, 1, 8'd255, 4'h8, 32'h01020304, 0, 0, 32'h0);
    applyStimulus(0, 0, 8'd255, 4'h0, 32'h0,        1, 0, 32'h01000000);
    idle();

    applyStimulus(1, 1, 8'd199, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0);
    applyStimulus(1, 0, 8'd199, 4'h0, 32'h0,        1, 0, 32'hCAFEF00D);
    applyStimulus(1, 1, 8'd210, 4'hF, 32'h55AA55AA, 0, 1, 32'h0);
    applyStimulus(1, 0, 8'd210, 4'hF, 32'h0,        1, 1, 32'h0);
    applyStimulus(1, 0, 8'd199, 4'h0, 32'h0,        1, 0, 32'hCAFEF00D);
    idle();
    repeat (2) @(negedge clk);

    // Reset lands right after the edge that accepts a read of addr 9.
    applyStimulus(0, 1, 8'd9, 4'hF, 32'h12345678, 0, 0, 32'h0);
    @(negedge clk);
    reqA = 1'b1; weA = 1'b0; addrA = 8'd9; beA = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    reqA  = 1'b0;
    #1;
    expectVal("midreset_rvalidA", {31'b0, rvalidA}, 32'h0);
    expectVal("midreset_errA",    {31'b0, errA},    32'h0);
    expectVal("midreset_rdataA",  rdataA,           32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fork
      waitReady(0, 256);
      waitReady(1, 200);
    join
    applyStimulus(0, 0, 8'd9,   4'h0, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 8'd199, 4'h0, 32'h0, 1, 0, 32'h0);
    idle();
    repeat (3) @(negedge clk);

    checks++;
    if (qA.size() + qB.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: %0d responses outstanding, required 0", qA.size() + qB.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
